// File: rtl/munoc_link_buffer_pkg.sv
// Shared sizing helpers for the MUNOC link buffer: link word width
// (payload plus a valid bit in the MSB), FIFO pointer width and occupancy width.
package munoc_link_buffer_pkg;

    // A link word is the phit payload with one valid bit on top.
    function automatic int bw_link(input int bw_phit);
        return bw_phit + 1;
    endfunction

    // Pointers index DEPTH entries; a single-entry FIFO still carries a 1-bit pointer.
    function automatic int bw_ptr(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must be able to represent 0..DEPTH inclusive.
    function automatic int bw_count(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/munoc_link_fifo.sv
// One direction of the link buffer: circular FIFO with optional fall-through
// bypass when empty, synchronous flush, occupancy output and a saturating
// stall monitor that flags an output blocked for STALL_LIMIT or more cycles.
module munoc_link_fifo
    import munoc_link_buffer_pkg::*;
#(
    parameter int BW_DATA     = 8,
    parameter int DEPTH       = 2,
    parameter int BYPASS      = 0,
    parameter int BW_STALL    = 8,
    parameter int STALL_LIMIT = 64
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic                       clear,
    input  logic                       i_wvalid,
    input  logic [BW_DATA-1:0]         i_wdata,
    output logic                       o_wready,
    output logic                       o_rvalid,
    output logic [BW_DATA-1:0]         o_rdata,
    input  logic                       i_rready,
    output logic [bw_count(DEPTH)-1:0] o_count,
    output logic                       o_stall
);

    localparam int                  PW          = bw_ptr(DEPTH);
    localparam int                  CW          = bw_count(DEPTH);
    localparam logic [PW-1:0]       PTR_LAST    = PW'(DEPTH - 1);
    localparam logic [CW-1:0]       DEPTH_C     = CW'(DEPTH);
    localparam logic [BW_STALL-1:0] STALL_MAX   = '1;
    localparam logic [BW_STALL-1:0] STALL_LIM_C = BW_STALL'(STALL_LIMIT);
    localparam logic                BYPASS_EN   = (BYPASS != 0);

    logic [BW_DATA-1:0]  r_mem [DEPTH];
    logic [PW-1:0]       r_wrPtr;
    logic [PW-1:0]       r_rdPtr;
    logic [PW-1:0]       w_wrPtrNext;
    logic [PW-1:0]       w_rdPtrNext;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_countNext;
    logic [BW_STALL-1:0] r_stallCnt;
    logic [BW_STALL-1:0] w_stallCntNext;
    logic                r_stall;
    logic                w_empty;
    logic                w_bypass;
    logic                w_bypassFire;
    logic                w_wfire;
    logic                w_rfire;
    logic                w_store;
    logic                w_pop;

    // Handshake and bypass selection; a word taken straight through the bypass is never stored.
    always_comb begin
        w_empty      = (r_count == '0);
        o_wready     = (r_count < DEPTH_C) & ~clear;
        w_bypass     = BYPASS_EN & w_empty & i_wvalid & ~clear & rstnn;
        o_rvalid     = (~w_empty & ~clear) | w_bypass;
        o_rdata      = w_bypass ? i_wdata : r_mem[r_rdPtr];
        w_wfire      = i_wvalid & o_wready;
        w_rfire      = o_rvalid & i_rready;
        w_bypassFire = w_bypass & i_rready;
        w_store      = w_wfire & ~w_bypassFire;
        w_pop        = w_rfire & ~w_bypassFire;
    end

    // Pointer wrap at DEPTH-1 so non-power-of-two depths use every entry.
    always_comb begin
        w_wrPtrNext = (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + 1'b1;
        w_rdPtrNext = (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + 1'b1;
    end

    // Occupancy follows stored writes minus array reads; a simultaneous pair cancels.
    always_comb begin
        w_countNext = r_count;
        if (clear) begin
            w_countNext = '0;
        end else if (w_store && !w_pop) begin
            w_countNext = r_count + 1'b1;
        end else if (!w_store && w_pop) begin
            w_countNext = r_count - 1'b1;
        end
    end

    // Stall counter grows while the output is offered but refused, saturates, and restarts otherwise.
    always_comb begin
        w_stallCntNext = '0;
        if (!clear && o_rvalid && !i_rready) begin
            w_stallCntNext = (r_stallCnt == STALL_MAX) ? r_stallCnt : r_stallCnt + 1'b1;
        end
    end

    // Storage array holds payload only; it needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy state; reset or flush empties the FIFO at once.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wrPtr <= w_wrPtrNext;
            end
            if (w_pop) begin
                r_rdPtr <= w_rdPtrNext;
            end
            r_count <= w_countNext;
        end
    end

    // Stall monitor state; the flag is registered from the counter value it will hold.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_stallCnt <= '0;
            r_stall    <= 1'b0;
        end else begin
            r_stallCnt <= w_stallCntNext;
            r_stall    <= (w_stallCntNext >= STALL_LIM_C);
        end
    end

    assign o_count = r_count;
    assign o_stall = r_stall;

endmodule

// File: rtl/munoc_link_buffer.sv
// Inter-router link buffer: one independently sized FIFO per direction
// (forward FNI, backward BNI). Link words are {valid, payload}; this level
// only splits the valid bit off the MSB and reassembles the outputs.
module munoc_link_buffer
    import munoc_link_buffer_pkg::*;
#(
    parameter int BW_FNI_PHIT = 8,
    parameter int BW_BNI_PHIT = 8,
    parameter int FNI_DEPTH   = 2,
    parameter int BNI_DEPTH   = 2,
    parameter int BYPASS      = 0,
    parameter int BW_STALL    = 8,
    parameter int STALL_LIMIT = 64
) (
    input  logic                              clk,
    input  logic                              rstnn,
    input  logic                              clear,
    input  logic [bw_link(BW_FNI_PHIT)-1:0]   rfni_link,
    output logic                              rfni_ready,
    output logic [bw_link(BW_FNI_PHIT)-1:0]   sfni_link,
    input  logic                              sfni_ready,
    input  logic [bw_link(BW_BNI_PHIT)-1:0]   sbni_link,
    output logic                              sbni_ready,
    output logic [bw_link(BW_BNI_PHIT)-1:0]   rbni_link,
    input  logic                              rbni_ready,
    output logic [bw_count(FNI_DEPTH)-1:0]    fni_count,
    output logic [bw_count(BNI_DEPTH)-1:0]    bni_count,
    output logic                              fni_stall,
    output logic                              bni_stall
);

    logic                   w_fniRvalid;
    logic [BW_FNI_PHIT-1:0] w_fniRdata;
    logic                   w_bniRvalid;
    logic [BW_BNI_PHIT-1:0] w_bniRdata;

    munoc_link_fifo #(
        .BW_DATA     (BW_FNI_PHIT),
        .DEPTH       (FNI_DEPTH),
        .BYPASS      (BYPASS),
        .BW_STALL    (BW_STALL),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_fni_fifo (
        .clk      (clk),
        .rstnn    (rstnn),
        .clear    (clear),
        .i_wvalid (rfni_link[BW_FNI_PHIT]),
        .i_wdata  (rfni_link[BW_FNI_PHIT-1:0]),
        .o_wready (rfni_ready),
        .o_rvalid (w_fniRvalid),
        .o_rdata  (w_fniRdata),
        .i_rready (sfni_ready),
        .o_count  (fni_count),
        .o_stall  (fni_stall)
    );

    munoc_link_fifo #(
        .BW_DATA     (BW_BNI_PHIT),
        .DEPTH       (BNI_DEPTH),
        .BYPASS      (BYPASS),
        .BW_STALL    (BW_STALL),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_bni_fifo (
        .clk      (clk),
        .rstnn    (rstnn),
        .clear    (clear),
        .i_wvalid (sbni_link[BW_BNI_PHIT]),
        .i_wdata  (sbni_link[BW_BNI_PHIT-1:0]),
        .o_wready (sbni_ready),
        .o_rvalid (w_bniRvalid),
        .o_rdata  (w_bniRdata),
        .i_rready (rbni_ready),
        .o_count  (bni_count),
        .o_stall  (bni_stall)
    );

    assign sfni_link = {w_fniRvalid, w_fniRdata};
    assign rbni_link = {w_bniRvalid, w_bniRdata};

endmodule
